// File: rtl/gsm_cell_dealloc_pkg.sv
// ----------------------------------------------------------------------------
// gsm_cell_dealloc_pkg
// Shared GSM definitions used by the allocator and the release side:
//   GSM_MWIDTH  - number of egress ports / multicast vector width
//   GSM_AWIDTH  - cell address width (2**GSM_AWIDTH cells)
//   clogb()     - ceiling log2, clogb(1) == 0
//   gsm_err_cause_e - error cause encodings, reserved for a later debug port
// ----------------------------------------------------------------------------
package gsm_cell_dealloc_pkg;

    localparam int GSM_MWIDTH = 4;
    localparam int GSM_AWIDTH = 7;

    typedef enum logic [1:0] {
        GSM_ERR_NONE      = 2'd0,
        GSM_ERR_UNDERFLOW = 2'd1,
        GSM_ERR_OVERFLOW  = 2'd2,
        GSM_ERR_DBL_REL   = 2'd3
    } gsm_err_cause_e;

    function automatic int clogb(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/gsm_cell_dealloc_if.sv
// ----------------------------------------------------------------------------
// gsm_cell_dealloc_if
// Release and free-FIFO handshakes of the GSM cell deallocator.
//   i_rel_valid [MWIDTH]        per-port release request
//   i_rel_addr  [MWIDTH*AWIDTH] per-port released address, port p at [p*AWIDTH +: AWIDTH]
//   o_rel_ready [MWIDTH]        one-hot grant
//   i_hmp_rd                    allocator pops the free FIFO
//   o_hmp_valid                 free FIFO non-empty
//   o_hmp_addr  [AWIDTH]        FIFO head, meaningful while o_hmp_valid
//
// Handshake rules: a release on port p is transferred in a cycle where
// i_rel_valid[p] & o_rel_ready[p] are both high at the rising clock edge; the
// requester holds valid and address stable until that happens. A pop is
// transferred when i_hmp_rd & o_hmp_valid; i_hmp_rd with o_hmp_valid low is
// an error and transfers nothing.
//
// master: egress readers / allocator side.  slave: the deallocator.
// ----------------------------------------------------------------------------
interface gsm_cell_dealloc_if
    import gsm_cell_dealloc_pkg::*;
#(
    parameter int MWIDTH = GSM_MWIDTH,
    parameter int AWIDTH = GSM_AWIDTH
) ();

    logic [MWIDTH-1:0]        i_rel_valid;
    logic [MWIDTH*AWIDTH-1:0] i_rel_addr;
    logic [MWIDTH-1:0]        o_rel_ready;
    logic                     i_hmp_rd;
    logic                     o_hmp_valid;
    logic [AWIDTH-1:0]        o_hmp_addr;

    modport master (
        output i_rel_valid,
        output i_rel_addr,
        output i_hmp_rd,
        input  o_rel_ready,
        input  o_hmp_valid,
        input  o_hmp_addr
    );

    modport slave (
        input  i_rel_valid,
        input  i_rel_addr,
        input  i_hmp_rd,
        output o_rel_ready,
        output o_hmp_valid,
        output o_hmp_addr
    );

endinterface

// File: rtl/gsm_cell_dealloc_free_fifo.sv
// ----------------------------------------------------------------------------
// gsm_free_fifo
// Show-ahead ring FIFO holding freed cell addresses.
//   clk, rst_n, clr          clock, async active-low reset, sync clear
//   i_push, i_push_data      write one entry (dropped when full)
//   i_pop                    remove head (ignored when empty)
//   o_valid, o_head          non-empty flag and combinational head
//   o_count                  occupancy, FAWIDTH+1 bits
//   o_overflow, o_underflow  same-cycle pulses for a dropped push / empty pop
// Pointers wrap naturally modulo 2**FAWIDTH.
// ----------------------------------------------------------------------------
module gsm_free_fifo #(
    parameter int DWIDTH  = 7,
    parameter int FAWIDTH = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               i_push,
    input  logic [DWIDTH-1:0]  i_push_data,
    input  logic               i_pop,
    output logic               o_valid,
    output logic [DWIDTH-1:0]  o_head,
    output logic [FAWIDTH:0]   o_count,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam int DEPTH = 2 ** FAWIDTH;
    localparam int CW    = FAWIDTH + 1;

    logic [DWIDTH-1:0]  mem_q [DEPTH];
    logic [FAWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FAWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [FAWIDTH:0]   count_q, count_d;
    logic               full;
    logic               push_ok;
    logic               pop_ok;

    assign full        = (count_q == CW'(DEPTH));
    assign o_valid     = (count_q != '0);
    assign o_head      = mem_q[rd_ptr_q];
    assign o_count     = count_q;
    // Pop qualifies on the registered valid, so a push into an empty FIFO
    // is never popped in the same cycle.
    assign pop_ok      = i_pop & o_valid;
    assign push_ok     = i_push & ~full;
    assign o_overflow  = i_push & full;
    assign o_underflow = i_pop & ~o_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_push_data;
        end
    end

endmodule

// File: rtl/gsm_cell_dealloc.sv
// ----------------------------------------------------------------------------
// gsm_cell_dealloc
// Release side of the GSM cell allocator. Keeps the multicast reference
// bitmap of every written cell, accepts per-port "read done" releases through
// a round-robin arbiter (one per cycle), clears the port bit, and pushes the
// address into a show-ahead free FIFO when the last reference is gone.
//
// Ports:
//   clk, rst_n, clr       clock, async active-low reset, sync clear
//   i_gsm_wr_en           allocator writes a cell this cycle
//   i_gsm_cell_addr       written cell address
//   i_gsm_multicast       destination ports of the written cell
//   bus (slave)           release handshake and free FIFO pop interface
//   o_bf_free_flag        one-cycle pulse per freed cell (cycle after release)
//   o_err                 sticky: FIFO under/overflow, double release,
//                         write/release collision on one address
// Optional (macro GSM_DEALLOC_STATS_EN):
//   o_freed_cnt[31:0]     count of o_bf_free_flag pulses
//   o_rel_cnt[MWIDTH*16]  per-port accepted release counters
// ----------------------------------------------------------------------------
module gsm_cell_dealloc
    import gsm_cell_dealloc_pkg::*;
#(
    parameter int MWIDTH      = GSM_MWIDTH,
    parameter int AWIDTH      = GSM_AWIDTH,
    parameter int FIFO_AWIDTH = AWIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                i_gsm_wr_en,
    input  logic [AWIDTH-1:0]   i_gsm_cell_addr,
    input  logic [MWIDTH-1:0]   i_gsm_multicast,
    gsm_cell_dealloc_if.slave   bus,
    output logic                o_bf_free_flag,
    output logic                o_err
`ifdef GSM_DEALLOC_STATS_EN
    ,
    output logic [31:0]         o_freed_cnt,
    output logic [MWIDTH*16-1:0] o_rel_cnt
`endif
);

    localparam int NCELL  = 2 ** AWIDTH;
    localparam int PW     = (MWIDTH > 1) ? clogb(MWIDTH) : 1;
    localparam int FDEPTH = 2 ** FIFO_AWIDTH;
    localparam int CW     = FIFO_AWIDTH + 1;

    // Reference bitmap: one bit per destination port still to read the cell.
    logic [MWIDTH-1:0] bitmap_q [NCELL];

    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              free_q, free_d;
    logic              err_q, err_d;

    logic              gnt_any;
    logic [PW-1:0]     gnt_port;
    logic [MWIDTH-1:0] grant;
    logic [AWIDTH-1:0] rel_addr;
    logic [MWIDTH-1:0] port_mask;
    logic [MWIDTH-1:0] old_bits;
    logic [MWIDTH-1:0] new_bits;
    logic              collide;
    logic              dbl_rel;
    logic              rel_ok;
    logic              push;

    logic              fifo_valid;
    logic [AWIDTH-1:0] fifo_head;
    logic [FIFO_AWIDTH:0] fifo_count;
    logic              fifo_ovf;
    logic              fifo_udf;

    // Round-robin: scan from rr_ptr_q upward, first requesting port wins.
    // No grant is offered while in reset or clear, so nothing is accepted.
    always_comb begin
        int idx;
        idx      = 0;
        gnt_any  = 1'b0;
        gnt_port = '0;
        for (int i = 0; i < MWIDTH; i++) begin
            idx = (int'(rr_ptr_q) + i) % MWIDTH;
            if (!gnt_any && bus.i_rel_valid[idx]) begin
                gnt_any  = 1'b1;
                gnt_port = PW'(idx);
            end
        end
        if (!rst_n || clr) begin
            gnt_any = 1'b0;
        end
        grant = gnt_any ? (MWIDTH'(1) << gnt_port) : '0;
    end

    assign bus.o_rel_ready = grant;

    // Decode of the accepted release.
    always_comb begin
        rel_addr  = bus.i_rel_addr[int'(gnt_port)*AWIDTH +: AWIDTH];
        port_mask = MWIDTH'(1) << gnt_port;
        old_bits  = bitmap_q[rel_addr];
        new_bits  = old_bits & ~port_mask;
        // A same-address write overrides the release entirely.
        collide   = gnt_any & i_gsm_wr_en & (i_gsm_cell_addr == rel_addr);
        dbl_rel   = gnt_any & ~collide & ((old_bits & port_mask) == '0);
        rel_ok    = gnt_any & ~collide & ~dbl_rel;
        push      = rel_ok & (new_bits == '0);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_any) begin
            if (gnt_port == PW'(MWIDTH - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_port + 1'b1;
            end
        end
        // Pulse only for addresses the FIFO actually takes.
        free_d = push & (fifo_count != CW'(FDEPTH));
        err_d  = err_q | collide | dbl_rel | fifo_ovf | fifo_udf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            free_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int c = 0; c < NCELL; c++) begin
                bitmap_q[c] <= '0;
            end
        end else if (clr) begin
            rr_ptr_q <= '0;
            free_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int c = 0; c < NCELL; c++) begin
                bitmap_q[c] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            free_q   <= free_d;
            err_q    <= err_d;
            if (rel_ok) begin
                bitmap_q[rel_addr] <= new_bits;
            end
            if (i_gsm_wr_en) begin
                bitmap_q[i_gsm_cell_addr] <= i_gsm_multicast;
            end
        end
    end

    gsm_free_fifo #(
        .DWIDTH  (AWIDTH),
        .FAWIDTH (FIFO_AWIDTH)
    ) u_free_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .i_push      (push),
        .i_push_data (rel_addr),
        .i_pop       (bus.i_hmp_rd),
        .o_valid     (fifo_valid),
        .o_head      (fifo_head),
        .o_count     (fifo_count),
        .o_overflow  (fifo_ovf),
        .o_underflow (fifo_udf)
    );

    assign bus.o_hmp_valid = fifo_valid;
    assign bus.o_hmp_addr  = fifo_head;
    assign o_bf_free_flag  = free_q;
    assign o_err           = err_q;

`ifdef GSM_DEALLOC_STATS_EN
    logic [31:0] freed_cnt_q;
    logic [15:0] rel_cnt_q [MWIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            freed_cnt_q <= '0;
            for (int p = 0; p < MWIDTH; p++) begin
                rel_cnt_q[p] <= '0;
            end
        end else if (clr) begin
            freed_cnt_q <= '0;
            for (int p = 0; p < MWIDTH; p++) begin
                rel_cnt_q[p] <= '0;
            end
        end else begin
            if (free_q) begin
                freed_cnt_q <= freed_cnt_q + 32'd1;
            end
            if (gnt_any) begin
                rel_cnt_q[gnt_port] <= rel_cnt_q[gnt_port] + 16'd1;
            end
        end
    end

    assign o_freed_cnt = freed_cnt_q;
    for (genvar g = 0; g < MWIDTH; g++) begin : g_rel_cnt
        assign o_rel_cnt[g*16 +: 16] = rel_cnt_q[g];
    end
`endif

endmodule

// File: doc/gsm_cell_dealloc.md
Name: gsm_cell_dealloc

Overview:
Release-side counterpart of the GSM cell allocator.
- Records the multicast vector of every cell written into the GSM.
- Accepts "cell read done" releases from the MWIDTH egress port readers and clears the matching port bit per release.
- When a cell's last reference clears, returns the address to a show-ahead free-address FIFO. The allocator pops this FIFO (hmp interface) and counts the frees (bf_free_flag).

Parameters:
MWIDTH, 4, number of output ports / multicast vector width
AWIDTH, 7, cell address width; 2**AWIDTH cells
FIFO_AWIDTH, AWIDTH, free FIFO pointer width; depth 2**FIFO_AWIDTH, must hold every cell

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear; same effect as reset
i_gsm_wr_en  in  1  allocator writes a cell this cycle
i_gsm_cell_addr  in  AWIDTH  written cell address
i_gsm_multicast  in  MWIDTH  destination ports of the written cell
i_rel_valid  in  MWIDTH  per-port release request
i_rel_addr  in  MWIDTH*AWIDTH  per-port released address; port p uses bits [p*AWIDTH +: AWIDTH]
o_rel_ready  out  MWIDTH  one-hot grant; release of port p accepted when i_rel_valid[p] & o_rel_ready[p]
i_hmp_rd  in  1  allocator pops the free FIFO
o_hmp_valid  out  1  free FIFO non-empty
o_hmp_addr  out  AWIDTH  FIFO head; valid while o_hmp_valid
o_bf_free_flag  out  1  one-cycle pulse per freed cell
o_err  out  1  sticky error: FIFO underflow/overflow, or a release of a bit that is already clear

Behaviour:
- Reset/clr values:
  - All bitmap entries 0; FIFO empty (pointers and count 0).
  - o_rel_ready 0, o_hmp_valid 0, o_bf_free_flag 0, o_err 0.
  - Round-robin pointer set to port 0.
  - Cells that have never been allocated are not held in the FIFO; the allocator's address generator covers them.
- Reference bitmap: array of 2**AWIDTH x MWIDTH flops. On i_gsm_wr_en, entry[i_gsm_cell_addr] <= i_gsm_multicast.
- Arbitration:
  - Combinational round-robin over i_rel_valid.
  - At most one grant per cycle; o_rel_ready is one-hot or zero.
  - The pointer advances to (granted port + 1) mod MWIDTH only on an accepted release.
- Release at cycle T (accepted port p, address a):
  - nv = entry[a] & ~(1<<p); entry[a] <= nv at the end of T.
  - If entry[a][p] was already 0: set o_err, no other effect.
  - If nv == 0: push a into the FIFO at the end of T. o_bf_free_flag is high during T+1, and o_hmp_valid reflects the push in T+1.
- Write/release collision on the same address in the same cycle: the write wins, o_err is set. The allocator never reallocates a live cell, so this only arises from a bug.
- Free FIFO:
  - Ring buffer with a count of FIFO_AWIDTH+1 bits. o_hmp_addr = mem[rd_ptr], combinational show-ahead.
  - Pop on i_hmp_rd & o_hmp_valid.
  - Simultaneous push and pop: count unchanged and both pointers advance. Pushing when empty with a same-cycle i_hmp_rd is not a pop (valid was 0).
  - i_hmp_rd when empty sets o_err and is otherwise ignored.
  - Push when full sets o_err and is dropped; this is impossible with the default sizing.
- Pointer wrap: natural modulo 2**FIFO_AWIDTH.
- Reset asserted mid-operation clears all state immediately; releases in flight are lost.

Optional Feature:
GSM_DEALLOC_STATS_EN
- Defined: adds output o_freed_cnt[31:0], counting o_bf_free_flag pulses (wraps at 2**32, cleared by rst_n/clr), and o_rel_cnt[MWIDTH*16-1:0], a per-port accepted-release counter (16 bits each, wrapping).
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/header: GSM widths (MWIDTH, AWIDTH) and the clogb function already shared with the allocator; error-cause encodings if exposed later.
- One natural sub-module: gsm_free_fifo. Show-ahead ring FIFO with push, pop, valid, head, count, and overflow/underflow outputs, parameterised by data width and FIFO_AWIDTH.

Test Plan:
- Write addr 5 with multicast 4'b0011; release port0 addr 5 -> no free. Release port1 addr 5 -> o_bf_free_flag pulses once, o_hmp_valid=1, o_hmp_addr=5 next cycle.
- Ports 0-3 all valid with addr 9 (multicast 4'b1111) held continuously -> grants in order 0,1,2,3, one per cycle. Single free of 9 after the 4th grant; o_err stays 0.
- Free addr 3 then addr 7; assert i_hmp_rd on the cycle after 7 is pushed -> o_hmp_addr is 3 then 7, and o_hmp_valid drops after the second pop.
- Simultaneous push of addr 12 and pop of addr 3 with count=1 -> count stays 1, head becomes 12.
- Release port2 addr 20 whose bitmap is 4'b0001 -> o_err=1, bitmap unchanged, no free pulse. i_hmp_rd when empty -> o_err stays 1.
- Free 128 cells, then assert rst_n=0 for one cycle mid-stream -> FIFO empty, o_hmp_valid=0, all outputs at reset values in the same cycle.
